// File: rtl/conv_pkg.sv
// Shared types and kernel geometry for the 3x3 convolution frame sequencer.
package conv_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD0,
      RD1,
      RD2,
      DRAIN,
      WRITE,
      DONE
   } state_e;

   localparam int unsigned PIX_W    = 8;
   localparam int unsigned ROW_W    = 3 * PIX_W;
   localparam int unsigned KERNEL_W = 3 * ROW_W;

   function automatic logic [ROW_W-1:0] kernel_row(input logic [KERNEL_W-1:0] k,
                                                   input int unsigned          idx);
      return k[idx*ROW_W +: ROW_W];
   endfunction

endpackage

// File: rtl/conv_pos_counter.sv
// Window position tracker: row/col, row base address and output address,
// with a flag marking the bottom-right (last) window.
module conv_pos_counter #(
   parameter int unsigned IMG_W  = 16,
   parameter int unsigned IMG_H  = 16,
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear_i,
   input  logic              advance_i,
   output logic [ADDR_W-1:0] base_o,
   output logic [ADDR_W-1:0] next_base_o,
   output logic [ADDR_W-1:0] out_addr_o,
   output logic              last_o
);

   localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(IMG_W - 3);
   localparam logic [ADDR_W-1:0] R_LAST = ADDR_W'(IMG_H - 3);
   localparam logic [ADDR_W-1:0] W_A    = ADDR_W'(IMG_W);
   localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

   logic [ADDR_W-1:0] r_q, r_d;
   logic [ADDR_W-1:0] c_q, c_d;
   logic [ADDR_W-1:0] row_base_q, row_base_d;
   logic [ADDR_W-1:0] out_addr_q, out_addr_d;

   always_comb begin
      r_d        = r_q;
      c_d        = c_q;
      row_base_d = row_base_q;
      out_addr_d = out_addr_q;
      if (clear_i) begin
         r_d        = '0;
         c_d        = '0;
         row_base_d = '0;
         out_addr_d = '0;
      end else if (advance_i) begin
         out_addr_d = out_addr_q + ONE;
         if (c_q < C_LAST) begin
            c_d = c_q + ONE;
         end else begin
            c_d        = '0;
            r_d        = r_q + ONE;
            row_base_d = row_base_q + W_A;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_q        <= '0;
         c_q        <= '0;
         row_base_q <= '0;
         out_addr_q <= '0;
      end else begin
         r_q        <= r_d;
         c_q        <= c_d;
         row_base_q <= row_base_d;
         out_addr_q <= out_addr_d;
      end
   end

   // next_base lets the FSM register the RD0 address in the same edge the position moves
   assign base_o      = row_base_q + c_q;
   assign next_base_o = row_base_d + c_d;
   assign out_addr_o  = out_addr_q;
   assign last_o      = (r_q == R_LAST) && (c_q == C_LAST);

endmodule

// File: rtl/conv_frame_sequencer.sv
// Frame controller: walks every valid 3x3 window, issuing RAM row reads,
// MAC weight/control one cycle behind, and a handshaked output write.
module conv_frame_sequencer
   import conv_pkg::*;
#(
   parameter int unsigned IMG_W  = 16,
   parameter int unsigned IMG_H  = 16,
   parameter int unsigned ADDR_W = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [KERNEL_W-1:0] kernel,
   input  logic                out_ready,
   output logic                busy,
   output logic                done,
   output logic                ram_en,
   output logic [ADDR_W-1:0]   ram_addr,
   output logic [ROW_W-1:0]    weight,
   output logic                mac_en,
   output logic                mac_clear,
   output logic                out_we,
   output logic [ADDR_W-1:0]   out_addr
);

   if (IMG_W < 3 || IMG_H < 3 || (64'(1) << ADDR_W) < 64'(IMG_W * IMG_H)) begin : g_bad_params
      $error("conv_frame_sequencer: bad IMG_W/IMG_H/ADDR_W");
   end

   localparam logic [ADDR_W-1:0] W1_A = ADDR_W'(IMG_W);
   localparam logic [ADDR_W-1:0] W2_A = ADDR_W'(2 * IMG_W);

   state_e              state_q;
   logic [KERNEL_W-1:0] kernel_q;
   logic                busy_q, done_q, ram_en_q, mac_en_q, mac_clear_q, out_we_q;
   logic [ADDR_W-1:0]   ram_addr_q;
   logic [ROW_W-1:0]    weight_q;

   logic [ADDR_W-1:0]   base, next_base;
   logic                last_win;
   logic                pos_clear, pos_advance;

   assign pos_clear   = (state_q == IDLE) && start;
   assign pos_advance = (state_q == WRITE) && out_ready;

   conv_pos_counter #(
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .ADDR_W (ADDR_W)
   ) u_pos (
      .clk         (clk),
      .reset       (reset),
      .clear_i     (pos_clear),
      .advance_i   (pos_advance),
      .base_o      (base),
      .next_base_o (next_base),
      .out_addr_o  (out_addr),
      .last_o      (last_win)
   );

   // Outputs are registered, so each arm drives the values seen in the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         kernel_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ram_en_q    <= 1'b0;
         ram_addr_q  <= '0;
         weight_q    <= '0;
         mac_en_q    <= 1'b0;
         mac_clear_q <= 1'b0;
         out_we_q    <= 1'b0;
      end else begin
         done_q      <= 1'b0;
         ram_en_q    <= 1'b0;
         mac_en_q    <= 1'b0;
         mac_clear_q <= 1'b0;
         out_we_q    <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  kernel_q   <= kernel;
                  state_q    <= RD0;
                  busy_q     <= 1'b1;
                  ram_en_q   <= 1'b1;
                  ram_addr_q <= next_base;
               end
            end
            RD0: begin
               state_q     <= RD1;
               ram_en_q    <= 1'b1;
               ram_addr_q  <= base + W1_A;
               mac_en_q    <= 1'b1;
               mac_clear_q <= 1'b1;
               weight_q    <= kernel_row(kernel_q, 0);
            end
            RD1: begin
               state_q    <= RD2;
               ram_en_q   <= 1'b1;
               ram_addr_q <= base + W2_A;
               mac_en_q   <= 1'b1;
               weight_q   <= kernel_row(kernel_q, 1);
            end
            RD2: begin
               state_q  <= DRAIN;
               mac_en_q <= 1'b1;
               weight_q <= kernel_row(kernel_q, 2);
            end
            DRAIN: begin
               state_q  <= WRITE;
               out_we_q <= 1'b1;
            end
            WRITE: begin
               if (!out_ready) begin
                  out_we_q <= 1'b1;
               end else if (last_win) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  state_q    <= RD0;
                  ram_en_q   <= 1'b1;
                  ram_addr_q <= next_base;
               end
            end
            DONE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign ram_en    = ram_en_q;
   assign ram_addr  = ram_addr_q;
   assign weight    = weight_q;
   assign mac_en    = mac_en_q;
   assign mac_clear = mac_clear_q;
   assign out_we    = out_we_q;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Directed + randomized bench for conv_frame_sequencer (4x4 and 3x3 instances),
// checked against a window/phase arithmetic model of the frame schedule.
module tb_conv_frame_sequencer;

   logic        clk = 1'b0;
   logic        reset, start, out_ready, sel3;
   logic [71:0] kernel;
   int          checks = 0;
   int          failures = 0;
   int          cyc_ctr = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc_ctr++;

   logic        start4, start3;
   logic        busy4, done4, ram_en4, mac_en4, mac_clear4, out_we4;
   logic        busy3, done3, ram_en3, mac_en3, mac_clear3, out_we3;
   logic [7:0]  ram_addr4, out_addr4, ram_addr3, out_addr3;
   logic [23:0] weight4, weight3;

   assign start4 = start & ~sel3;
   assign start3 = start & sel3;

   conv_frame_sequencer #(.IMG_W(4), .IMG_H(4), .ADDR_W(8)) dut (
      .clk(clk), .reset(reset), .start(start4), .kernel(kernel), .out_ready(out_ready),
      .busy(busy4), .done(done4), .ram_en(ram_en4), .ram_addr(ram_addr4), .weight(weight4),
      .mac_en(mac_en4), .mac_clear(mac_clear4), .out_we(out_we4), .out_addr(out_addr4));

   conv_frame_sequencer #(.IMG_W(3), .IMG_H(3), .ADDR_W(8)) dut3 (
      .clk(clk), .reset(reset), .start(start3), .kernel(kernel), .out_ready(out_ready),
      .busy(busy3), .done(done3), .ram_en(ram_en3), .ram_addr(ram_addr3), .weight(weight3),
      .mac_en(mac_en3), .mac_clear(mac_clear3), .out_we(out_we3), .out_addr(out_addr3));

   logic        o_busy, o_done, o_ram_en, o_mac_en, o_mac_clear, o_out_we;
   logic [7:0]  o_ram_addr, o_out_addr;
   logic [23:0] o_weight;
   assign o_busy      = sel3 ? busy3      : busy4;
   assign o_done      = sel3 ? done3      : done4;
   assign o_ram_en    = sel3 ? ram_en3    : ram_en4;
   assign o_mac_en    = sel3 ? mac_en3    : mac_en4;
   assign o_mac_clear = sel3 ? mac_clear3 : mac_clear4;
   assign o_out_we    = sel3 ? out_we3    : out_we4;
   assign o_ram_addr  = sel3 ? ram_addr3  : ram_addr4;
   assign o_out_addr  = sel3 ? out_addr3  : out_addr4;
   assign o_weight    = sel3 ? weight3    : weight4;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ra < 0 skips the ram_addr check; weight is checked only when mac_en is expected
   task automatic expect_cyc(input string ph, input bit e_busy, input bit e_done,
                             input bit e_ren, input bit e_men, input bit e_mclr,
                             input bit e_owe, input int ra, input logic [23:0] w,
                             input int oa);
      chk({ph, " busy"},      32'(o_busy),      32'(e_busy));
      chk({ph, " done"},      32'(o_done),      32'(e_done));
      chk({ph, " ram_en"},    32'(o_ram_en),    32'(e_ren));
      chk({ph, " mac_en"},    32'(o_mac_en),    32'(e_men));
      chk({ph, " mac_clear"}, 32'(o_mac_clear), 32'(e_mclr));
      chk({ph, " out_we"},    32'(o_out_we),    32'(e_owe));
      if (ra >= 0) chk({ph, " ram_addr"}, 32'(o_ram_addr), 32'(ra));
      if (e_men)   chk({ph, " weight"},   32'(o_weight),   32'(w));
      chk({ph, " out_addr"}, 32'(o_out_addr), 32'(oa));
   endtask

   task automatic step(input bit poke);
      if (poke) begin
         start  = 1'b1;
         kernel = {8'($urandom), 32'($urandom), 32'($urandom)};
      end
      @(negedge clk);
   endtask

   // Drives start at a negedge while the DUT is idle, then checks every cycle
   // of the frame. done_cyc counts edges from the start cycle to the done cycle.
   task automatic run_frame(input int W, input int H, input logic [71:0] k,
                            input int stall0, input bit rnd, input bit poke,
                            output int stalls_tot, output int done_cyc);
      int nw, wc, r, c, b, n, t0, lastb;
      nw = (W - 2) * (H - 2);
      wc = W - 2;
      stalls_tot = 0;
      kernel = k;
      start = 1'b1;
      out_ready = 1'b1;
      t0 = cyc_ctr;
      @(negedge clk);
      if (!poke) start = 1'b0;
      for (int win = 0; win < nw; win++) begin
         r = win / wc;
         c = win % wc;
         b = r * W + c;
         expect_cyc("rd0",   1, 0, 1, 0, 0, 0, b,         24'h0,     win); step(poke);
         expect_cyc("rd1",   1, 0, 1, 1, 1, 0, b + W,     k[23:0],   win); step(poke);
         expect_cyc("rd2",   1, 0, 1, 1, 0, 0, b + 2 * W, k[47:24],  win); step(poke);
         expect_cyc("drain", 1, 0, 0, 1, 0, 0, b + 2 * W, k[71:48],  win); step(poke);
         n = (win == 0) ? stall0 : (rnd ? int'($urandom_range(0, 2)) : 0);
         stalls_tot += n;
         for (int s = 0; s <= n; s++) begin
            expect_cyc("write", 1, 0, 0, 0, 0, 1, b + 2 * W, 24'h0, win);
            out_ready = (s == n);
            step(poke);
         end
      end
      start = 1'b0;
      out_ready = 1'b1;
      lastb = (H - 3) * W + (W - 3) + 2 * W;
      done_cyc = cyc_ctr - t0;
      expect_cyc("done", 0, 1, 0, 0, 0, 0, lastb, 24'h0, nw);
      @(negedge clk);
      expect_cyc("idle", 0, 0, 0, 0, 0, 0, lastb, 24'h0, nw);
      @(negedge clk);
      expect_cyc("idle2", 0, 0, 0, 0, 0, 0, lastb, 24'h0, nw);
   endtask

   initial begin
      int st, dc;
      logic [71:0] kr;
      reset = 1'b1; start = 1'b0; out_ready = 1'b1; sel3 = 1'b0; kernel = '0;
      repeat (2) @(negedge clk);
      expect_cyc("reset4", 0, 0, 0, 0, 0, 0, 0, 24'h0, 0);
      chk("reset4 weight", 32'(o_weight), 32'h0);
      sel3 = 1'b1;
      expect_cyc("reset3", 0, 0, 0, 0, 0, 0, 0, 24'h0, 0);
      sel3 = 1'b0;
      reset = 1'b0;
      @(negedge clk);

      run_frame(4, 4, 72'h090807_060504_030201, 0, 0, 0, st, dc);
      chk("baseline done_cycle", 32'(dc), 32'd21);

      run_frame(4, 4, 72'h090807_060504_030201, 3, 0, 0, st, dc);
      chk("stall3 done_cycle", 32'(dc), 32'd24);

      kr = {8'($urandom), 32'($urandom), 32'($urandom)};
      run_frame(4, 4, kr, 0, 0, 1, st, dc);
      chk("poke done_cycle", 32'(dc), 32'd21);

      // reset in RD2 of window 2 (cycle 13), with a start in the same cycle
      kernel = 72'h090807_060504_030201;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (12) @(negedge clk);
      expect_cyc("pre_reset rd2", 1, 0, 1, 1, 0, 0, 12, 24'h060504, 2);
      reset = 1'b1;
      start = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      expect_cyc("midreset", 0, 0, 0, 0, 0, 0, 0, 24'h0, 0);
      chk("midreset weight", 32'(o_weight), 32'h0);
      @(negedge clk);
      expect_cyc("midreset idle", 0, 0, 0, 0, 0, 0, 0, 24'h0, 0);
      run_frame(4, 4, 72'h090807_060504_030201, 0, 0, 0, st, dc);
      chk("replay done_cycle", 32'(dc), 32'd21);

      sel3 = 1'b1;
      run_frame(3, 3, 72'h112233_445566_778899, 0, 0, 0, st, dc);
      chk("3x3 done_cycle", 32'(dc), 32'd6);
      sel3 = 1'b0;

      for (int i = 0; i < 5; i++) begin
         kr = {8'($urandom), 32'($urandom), 32'($urandom)};
         run_frame(4, 4, kr, int'($urandom_range(0, 3)), 1, 1'($urandom_range(0, 1)), st, dc);
         chk("rand done_cycle", 32'(dc), 32'(21 + st));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
